// File: rtl/pwm_counter.sv
// PWM timebase and comparator: edge- or centre-aligned counter with double-buffered
// period/duty/mode, registered PWM output and a one-cycle period-boundary pulse.
module pwm_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 cnt_en,
  input  logic                 mode_in,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [CNT_WIDTH-1:0] duty_in,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 dir_out,
  output logic                 tc_out,
  output logic                 pwm_out
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] ps, ds;
  logic                 ms;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 dir_nxt;
  logic                 bnd;

  always_comb begin
    cnt_nxt = cnt_out;
    dir_nxt = dir_out;
    bnd     = 1'b0;
    if (cnt_en) begin
      if (!ms) begin
        dir_nxt = 1'b0;
        if (cnt_out >= ps) begin
          cnt_nxt = '0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = cnt_out + ONE;
        end
      end else if (!dir_out) begin
        if (cnt_out < ps) begin
          cnt_nxt = cnt_out + ONE;
        end else if (ps <= ONE) begin
          // Ps of 0 or 1 has no down leg: the turn-around lands straight on the period start
          cnt_nxt = '0;
          dir_nxt = 1'b0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = ps - ONE;
          dir_nxt = 1'b1;
        end
      end else begin
        if (cnt_out > ONE) begin
          cnt_nxt = cnt_out - ONE;
        end else begin
          cnt_nxt = '0;
          dir_nxt = 1'b0;
          bnd     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_out <= '0;
      dir_out <= 1'b0;
      tc_out  <= 1'b0;
      pwm_out <= 1'b0;
      ps      <= '0;
      ds      <= '0;
      ms      <= 1'b0;
    end else begin
      cnt_out <= cnt_nxt;
      dir_out <= dir_nxt;
      tc_out  <= bnd;
      pwm_out <= (cnt_out < ds);
      if (bnd) begin
        ps <= period_in;
        ds <= duty_in;
        ms <= mode_in;
      end
    end
  end

endmodule

// File: tb/tb_pwm_counter.sv
// Bench for pwm_counter: directed scenarios plus random stimulus against a model that
// replays each period as a precomputed list of (count, direction) positions.
module tb_pwm_counter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] period = '0;
  logic [W-1:0] duty = '0;
  logic [W-1:0] cnt;
  logic         dir, tc, pwm;

  pwm_counter #(.CNT_WIDTH(W)) dut (
    .clk_in(clk), .rst_in(rst), .cnt_en(en), .mode_in(mode),
    .period_in(period), .duty_in(duty),
    .cnt_out(cnt), .dir_out(dir), .tc_out(tc), .pwm_out(pwm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: one period as an explicit list of positions
  int q_cnt[$];
  bit q_dir[$];
  int idx;
  int m_ps, m_ds;
  bit m_ms;
  int m_cnt;
  bit m_dir, m_tc, m_pwm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void build_period();
    q_cnt.delete();
    q_dir.delete();
    for (int i = 0; i <= m_ps; i++) begin
      q_cnt.push_back(i);
      q_dir.push_back(1'b0);
    end
    if (m_ms)
      for (int i = m_ps - 1; i >= 1; i--) begin
        q_cnt.push_back(i);
        q_dir.push_back(1'b1);
      end
  endfunction

  task automatic model_reset();
    m_ps = 0; m_ds = 0; m_ms = 1'b0;
    build_period();
    idx = 0;
    m_cnt = 0; m_dir = 1'b0; m_tc = 1'b0; m_pwm = 1'b0;
  endtask

  task automatic model_step();
    bit npwm;
    npwm = (m_cnt < m_ds);
    m_tc = 1'b0;
    if (en) begin
      idx++;
      if (idx >= q_cnt.size()) begin
        m_ps = int'(period); m_ds = int'(duty); m_ms = mode;
        build_period();
        idx = 0;
        m_tc = 1'b1;
      end
    end
    m_cnt = q_cnt[idx];
    m_dir = q_dir[idx];
    m_pwm = npwm;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"}, cnt, m_cnt);
    chk({tag, ".dir"}, dir, m_dir);
    chk({tag, ".tc"}, tc, m_tc);
    chk({tag, ".pwm"}, pwm, m_pwm);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_cfg(input bit md, input int p, input int d);
    mode = md; period = W'(p); duty = W'(d);
  endtask

  int k;
  int hi;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");

    // edge mode P=4 D=2
    set_cfg(1'b0, 4, 2);
    en = 1'b1;
    rst = 1'b0;
    run("edge", 16);
    chk("edge.tc_at_zero", (m_tc && m_cnt != 0), 0);

    // centre mode P=3 D=2; count pwm-high cycles over one period after its start
    set_cfg(1'b1, 3, 2);
    for (k = 0; k < 20 && !(m_tc && m_ms); k++) step("ctr_sync");
    chk("ctr_sync.reached", (m_tc && m_ms), 1);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      step("ctr");
      hi += int'(pwm);
    end
    chk("ctr.pwm_high", hi, 3);
    run("ctr", 8);

    // mid-period change in edge mode
    set_cfg(1'b0, 4, 2);
    for (k = 0; k < 40 && !(m_ms == 0 && m_ps == 4 && m_cnt == 2); k++) step("mid_sync");
    chk("mid_sync.reached", (m_ps == 4 && m_cnt == 2), 1);
    set_cfg(1'b0, 7, 7);
    run("mid", 3);
    chk("mid.end_at_4", {tc, cnt}, {1'b1, 8'd0});
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step("mid_new");
      hi += int'(pwm);
    end
    chk("mid_new.pwm_high", hi, 7);

    // enable hold at cnt=3
    set_cfg(1'b0, 4, 2);
    for (k = 0; k < 40 && !(m_ps == 4 && m_cnt == 3); k++) step("hold_sync");
    chk("hold_sync.reached", (m_ps == 4 && m_cnt == 3), 1);
    en = 1'b0;
    run("hold", 3);
    en = 1'b1;
    run("hold_resume", 8);

    // duty extremes and P=0
    set_cfg(1'b0, 4, 0);   run("d0", 14);
    set_cfg(1'b0, 4, 5);   run("d5", 14);
    set_cfg(1'b0, 4, 255); run("d255", 14);
    set_cfg(1'b0, 0, 1);   run("p0", 8);
    set_cfg(1'b1, 0, 1);   run("p0c", 6);
    set_cfg(1'b1, 1, 1);   run("p1c", 10);

    // async reset during centre down-count at cnt=2
    set_cfg(1'b1, 3, 2);
    for (k = 0; k < 60 && !(m_ms && m_dir && m_cnt == 2); k++) step("rst_sync");
    chk("rst_sync.reached", (m_ms && m_dir && m_cnt == 2), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    run("post_rst", 12);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      mode = $urandom_range(0, 1);
      case ($urandom_range(0, 31))
        0:       period = 8'd255;
        1:       period = W'($urandom_range(10, 40));
        default: period = W'($urandom_range(0, 9));
      endcase
      duty = ($urandom_range(0, 15) == 0) ? 8'd255 : W'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
